button_pulse_gen: RTL and testbench

- Input-side front end for the watch controller. Converts two raw push buttons (outside and inside) into the clean single-cycle set_outside / set_inside strobes the controller consumes.
- Per button: synchronises, debounces, emits one pulse per press.
- While a button is held past a long-press threshold, it emits auto-repeat pulses for fast time adjustment.
- Sits between board KEY pins and the controller / count_display blocks.

---
 rtl/watch_pkg.sv | 33 +++
 rtl/button_pulse_gen_if.sv | 20 ++
 rtl/button_channel.sv | 114 +++++++++++
 rtl/button_pulse_gen.sv | 42 ++++
 tb/tb_button_pulse_gen.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/watch_pkg.sv
// Shared types and default timing constants for the watch controller front end.
// Channel FSM encoding plus helpers for sizing the per-channel counter.
package watch_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    DEB_REL   = 3'd4
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_LONG_CYCLES     = 16;
  localparam int unsigned DEF_REPEAT_CYCLES   = 8;
  localparam int unsigned DEF_BTN_ACTIVE_LOW  = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One extra bit beyond clog2 keeps the terminal compare in range for powers of two.
  function automatic int unsigned cnt_width(input int unsigned d, input int unsigned l,
                                            input int unsigned r);
    return $clog2(max3(d, l, r)) + 1;
  endfunction

endpackage

// File: rtl/button_pulse_gen_if.sv
// Raw button pins in, clean strobes and long-press levels out.
// The slave side is the pulse generator; the master side drives the pins.
interface button_pulse_gen_if;
  logic btn_outside_raw;
  logic btn_inside_raw;
  logic set_outside;
  logic set_inside;
  logic long_outside;
  logic long_inside;

  modport master (
    output btn_outside_raw, btn_inside_raw,
    input  set_outside, set_inside, long_outside, long_inside
  );

  modport slave (
    input  btn_outside_raw, btn_inside_raw,
    output set_outside, set_inside, long_outside, long_inside
  );
endinterface

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, polarity fix, debounce/long-press/repeat FSM.
// Emits a registered one-cycle strobe per accepted press and per repeat tick.
module button_channel
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic strobe,
  output logic long_press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic RELEASED = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             p;
  btn_state_t       state;
  btn_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             pulse_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign p = sync2 ^ RELEASED;

  always_comb begin
    next_state = state;
    cnt_next   = cnt + 1'b1;
    pulse_next = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (p) next_state = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!p) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          next_state = HELD;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end
      end
      HELD: begin
        if (!p) begin
          next_state = DEB_REL;
          cnt_next   = '0;
        end else if (cnt == LONG_LAST) begin
          next_state = REPEAT;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end
      end
      REPEAT: begin
        if (!p) begin
          next_state = DEB_REL;
          cnt_next   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_next   = '0;
          pulse_next = 1'b1;
        end
      end
      DEB_REL: begin
        // A press seen while debouncing release is a bounce: back to HELD, long timer restarts.
        if (p) begin
          next_state = HELD;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          next_state = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      strobe     <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      strobe     <= pulse_next;
      long_press <= (next_state == REPEAT);
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Front end for the watch controller: two independent button channels.
// Only wires parameters and interface signals to the channel instances.
module button_pulse_gen
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             reset,
  button_pulse_gen_if.slave btn
);

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_outside (
    .clk       (clk),
    .reset     (reset),
    .raw       (btn.btn_outside_raw),
    .strobe    (btn.set_outside),
    .long_press(btn.long_outside)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_inside (
    .clk       (clk),
    .reset     (reset),
    .raw       (btn.btn_inside_raw),
    .strobe    (btn.set_inside),
    .long_press(btn.long_inside)
  );

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with default timing, active-low buttons.
// Expected strobe edges and long-press windows are hand-computed per scenario.
module tb_button_pulse_gen;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  button_pulse_gen_if bif ();

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16),
    .REPEAT_CYCLES  (8),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (bif.slave)
  );

  // Pressed windows are edge ranges (0 = unused); strobe lists hold up to 8 edge numbers.
  typedef struct {
    string       name;
    int          o1l, o1h, o2l, o2h;
    int          i1l, i1h;
    int          rl, rh;
    int          n;
    logic [63:0] so;
    logic [63:0] si;
    int          lol, loh;
    int          lil, lih;
  } vec_t;

  vec_t vecs[6];

  function automatic bit inwin(input int e, input int l, input int h);
    return (l > 0) && (e >= l) && (e <= h);
  endfunction

  function automatic bit in_list(input int e, input logic [63:0] l);
    for (int k = 0; k < 8; k++)
      if (e > 0 && l[k*8 +: 8] == 8'(e)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic o_raw, input logic i_raw);
    @(negedge clk);
    reset               = r;
    bif.btn_outside_raw = o_raw;
    bif.btn_inside_raw  = i_raw;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int e, input logic [3:0] exp);
    logic [3:0] got;
    got = {bif.set_outside, bif.set_inside, bif.long_outside, bif.long_inside};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: {set_o,set_i,long_o,long_i} got %b expected %b",
               name, e, got, exp);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b1);
      check("reset_hold", -k, 4'b0000);
    end
  endtask

  initial begin
    reset               = 1'b0;
    bif.btn_outside_raw = 1'b1;
    bif.btn_inside_raw  = 1'b1;

    vecs[0] = '{"clean_press", 1, 10, 0, 0, 0, 0, 0, 0, 20,
                {8'd7, 56'd0}, 64'd0, 0, 0, 0, 0};
    vecs[1] = '{"long_hold", 1, 60, 0, 0, 0, 0, 0, 0, 70,
                {8'd7, 8'd23, 8'd31, 8'd39, 8'd47, 8'd55, 16'd0}, 64'd0, 23, 62, 0, 0};
    vecs[2] = '{"simultaneous", 1, 10, 0, 0, 1, 10, 0, 0, 20,
                {8'd7, 56'd0}, {8'd7, 56'd0}, 0, 0, 0, 0};
    vecs[3] = '{"reset_mid_hold", 1, 50, 0, 0, 0, 0, 20, 22, 60,
                {8'd7, 8'd29, 8'd45, 40'd0}, 64'd0, 45, 52, 0, 0};
    vecs[4] = '{"release_bounce", 1, 12, 15, 40, 0, 0, 0, 0, 50,
                {8'd7, 8'd33, 8'd41, 40'd0}, 64'd0, 33, 42, 0, 0};
    vecs[5] = '{"inside_long", 0, 0, 0, 0, 1, 40, 0, 0, 50,
                64'd0, {8'd7, 8'd23, 8'd31, 8'd39, 32'd0}, 0, 0, 23, 42};

    // Reset with both buttons released, then one cycle after release of reset.
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b1);
      check("reset_idle", k, 4'b0000);
    end
    step(1'b1, 1'b1, 1'b1);
    check("reset_exit", 4, 4'b0000);

    // Buttons pressed while reset is held must stay silent.
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check("reset_pressed", k, 4'b0000);
    end

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int e = 1; e <= vecs[v].n; e++) begin
        logic o, i, r;
        o = !(inwin(e, vecs[v].o1l, vecs[v].o1h) || inwin(e, vecs[v].o2l, vecs[v].o2h));
        i = !inwin(e, vecs[v].i1l, vecs[v].i1h);
        r = !inwin(e, vecs[v].rl, vecs[v].rh);
        step(r, o, i);
        check(vecs[v].name, e, {in_list(e, vecs[v].so), in_list(e, vecs[v].si),
                                inwin(e, vecs[v].lol, vecs[v].loh),
                                inwin(e, vecs[v].lil, vecs[v].lih)});
      end
    end

    // Bounce: 2-cycle press/release toggling must never strobe, and the
    // following clean press must show normal first-strobe latency.
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      logic o;
      o = !(inwin(e, 1, 2) || inwin(e, 5, 6) || inwin(e, 9, 10));
      step(1'b1, o, 1'b1);
      check("bounce", e, 4'b0000);
    end
    for (int e = 31; e <= 45; e++) begin
      step(1'b1, (e <= 40) ? 1'b0 : 1'b1, 1'b1);
      check("after_bounce", e, {(e == 37), 3'b000});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
